// File: rtl/uart_wb_dbg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_wb_dbg_pkg
// Description : Shared constants and the frame FSM state type for the
//               UART-to-Wishbone debug bridge.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_wb_dbg_pkg;

  localparam logic [7:0]  CMD_WRITE     = 8'h01;
  localparam logic [7:0]  CMD_READ      = 8'h02;
  // Word returned to the host when the slave terminates a read with an error.
  localparam logic [31:0] ERR_READ_DATA = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_GET_SIZE = 3'd1,
    ST_GET_ADDR = 3'd2,
    ST_GET_DATA = 3'd3,
    ST_WB_CYCLE = 3'd4,
    ST_SEND     = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_wb_dbg_phy.sv
`default_nettype none
// ============================================================================
// Module      : uart_wb_dbg_phy
// Description : 8N1 UART receiver and transmitter, LSB first.
// Ports       : clk, rst_n          - clock, async active-low reset
//               i_rx                - asynchronous serial input (idle high)
//               o_rx_valid/o_rx_byte- byte strobe, one cycle after stop sample
//               o_rx_frame_err      - pulse when the stop bit samples low
//               i_tx_start/i_tx_byte- load a byte when o_tx_ready is high
//               o_tx_ready          - TX can accept a byte this cycle
//               o_tx                - serial output (idle high)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_wb_dbg_phy #(
  parameter int CLKS_PER_BIT = 1042
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_byte,
  output logic       o_rx_frame_err,
  input  logic       i_tx_start,
  input  logic [7:0] i_tx_byte,
  output logic       o_tx_ready,
  output logic       o_tx
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] c_bit_last  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] c_half_last = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  rx_state_t     r_rx_state;
  logic [2:0]    r_rx_sync;   // [1] is the synchronised line, [2] its previous value
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bits;
  logic [7:0]    r_rx_shift;
  logic          r_rx_valid;
  logic          r_rx_ferr;
  logic          w_rx_line;
  logic          w_rx_fall;

  assign w_rx_line = r_rx_sync[1];
  assign w_rx_fall = r_rx_sync[2] & ~r_rx_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_sync  <= 3'b111;
      r_rx_state <= RX_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bits  <= '0;
      r_rx_shift <= '0;
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
    end else begin
      r_rx_sync  <= {r_rx_sync[1:0], i_rx};
      r_rx_valid <= 1'b0;
      r_rx_ferr  <= 1'b0;
      case (r_rx_state)
        RX_IDLE: begin
          r_rx_cnt <= '0;
          if (w_rx_fall) r_rx_state <= RX_START;
        end
        RX_START: begin
          // Half-bit re-check rejects glitches shorter than half a bit.
          if (r_rx_cnt == c_half_last) begin
            r_rx_cnt   <= '0;
            r_rx_bits  <= '0;
            r_rx_state <= w_rx_line ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == c_bit_last) begin
            r_rx_cnt   <= '0;
            r_rx_shift <= {w_rx_line, r_rx_shift[7:1]};
            r_rx_bits  <= r_rx_bits + 3'd1;
            if (r_rx_bits == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == c_bit_last) begin
            r_rx_state <= RX_IDLE;
            r_rx_valid <= w_rx_line;
            r_rx_ferr  <= ~w_rx_line;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign o_rx_valid     = r_rx_valid;
  assign o_rx_byte      = r_rx_shift;
  assign o_rx_frame_err = r_rx_ferr;

  // TX: bit 0 of the shifter is the line; it fills with ones so idle is high.
  logic [9:0]    r_tx_shift;
  logic          r_tx_busy;
  logic [CW-1:0] r_tx_cnt;
  logic [3:0]    r_tx_bits;
  logic          w_tx_ready;

  // Ready during the final stop-bit cycle so the next start bit follows directly.
  assign w_tx_ready = !r_tx_busy || (r_tx_cnt == c_bit_last && r_tx_bits == 4'd9);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shift <= '1;
      r_tx_busy  <= 1'b0;
      r_tx_cnt   <= '0;
      r_tx_bits  <= '0;
    end else if (i_tx_start && w_tx_ready) begin
      r_tx_shift <= {1'b1, i_tx_byte, 1'b0};
      r_tx_busy  <= 1'b1;
      r_tx_cnt   <= '0;
      r_tx_bits  <= '0;
    end else if (r_tx_busy) begin
      if (r_tx_cnt == c_bit_last) begin
        r_tx_cnt <= '0;
        if (r_tx_bits == 4'd9) begin
          r_tx_busy <= 1'b0;
        end else begin
          r_tx_shift <= {1'b1, r_tx_shift[9:1]};
          r_tx_bits  <= r_tx_bits + 4'd1;
        end
      end else begin
        r_tx_cnt <= r_tx_cnt + 1'b1;
      end
    end
  end

  assign o_tx_ready = w_tx_ready;
  assign o_tx       = r_tx_shift[0];

endmodule
`default_nettype wire

// File: rtl/uart_wb_dbg_bridge.sv
`default_nettype none
// ============================================================================
// Module      : uart_wb_dbg_bridge
// Description : UART debug slave / Wishbone master. Parses write (0x01) and
//               read (0x02) frames and issues 32-bit Wishbone cycles; read
//               data is returned MSB first on uart_tx.
// Ports       : HCLK, HRESETn     - clock, async active-low reset
//               uart_rx, uart_tx  - host serial link (8N1)
//               wb_*              - Wishbone master interface
//               busy_o            - frame in progress
//               frame_err_o       - pulse on framing error or timeout abort
// Revision    : 1.0 - initial release
// ============================================================================
module uart_wb_dbg_bridge
  import uart_wb_dbg_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 1042,
  parameter int FRAME_TIMEOUT = 20 * CLKS_PER_BIT
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic        busy_o,
  output logic        frame_err_o
);

  localparam int TW = $clog2(FRAME_TIMEOUT + 1);
  localparam logic [TW-1:0] c_to_last = TW'(FRAME_TIMEOUT - 1);

  logic       w_rx_valid;
  logic [7:0] w_rx_byte;
  logic       w_rx_ferr;
  logic       w_tx_ready;
  logic       w_tx_start;
  logic [7:0] w_tx_byte;

  state_t        r_state;
  state_t        w_next;
  logic          r_is_write;
  logic [7:0]    r_words;
  logic [1:0]    r_cnt;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_rdata;
  logic          r_send_done;
  logic [TW-1:0] r_to_cnt;
  logic          r_frame_err;
  logic          w_in_rx;
  logic          w_timeout;
  logic          w_bus_done;

  uart_wb_dbg_phy #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_phy (
    .clk            (HCLK),
    .rst_n          (HRESETn),
    .i_rx           (uart_rx),
    .o_rx_valid     (w_rx_valid),
    .o_rx_byte      (w_rx_byte),
    .o_rx_frame_err (w_rx_ferr),
    .i_tx_start     (w_tx_start),
    .i_tx_byte      (w_tx_byte),
    .o_tx_ready     (w_tx_ready),
    .o_tx           (uart_tx)
  );

  assign w_in_rx    = (r_state == ST_GET_SIZE) || (r_state == ST_GET_ADDR) ||
                      (r_state == ST_GET_DATA);
  assign w_timeout  = w_in_rx && !w_rx_valid && (r_to_cnt == c_to_last);
  assign w_bus_done = wb_ack_i || wb_err_i;
  // ~r_cnt == 3 - r_cnt: byte 0 is the most significant.
  assign w_tx_byte  = r_rdata[{~r_cnt, 3'b000} +: 8];

  always_comb begin
    w_next     = r_state;
    w_tx_start = 1'b0;
    case (r_state)
      ST_IDLE:
        if (w_rx_valid && (w_rx_byte == CMD_WRITE || w_rx_byte == CMD_READ))
          w_next = ST_GET_SIZE;
      ST_GET_SIZE:
        if (w_rx_valid) w_next = (w_rx_byte == 8'd0) ? ST_IDLE : ST_GET_ADDR;
      ST_GET_ADDR:
        if (w_rx_valid && r_cnt == 2'd3) w_next = r_is_write ? ST_GET_DATA : ST_WB_CYCLE;
      ST_GET_DATA:
        if (w_rx_valid && r_cnt == 2'd3) w_next = ST_WB_CYCLE;
      ST_WB_CYCLE:
        if (w_bus_done) begin
          if (!r_is_write)        w_next = ST_SEND;
          else if (r_words == 8'd1) w_next = ST_IDLE;
          else                    w_next = ST_GET_DATA;
        end
      ST_SEND: begin
        w_tx_start = !r_send_done && w_tx_ready;
        if (r_send_done && w_tx_ready)
          w_next = (r_words == 8'd1) ? ST_IDLE : ST_WB_CYCLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (w_in_rx && (w_rx_ferr || w_timeout)) w_next = ST_IDLE;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state     <= ST_IDLE;
      r_is_write  <= 1'b0;
      r_words     <= '0;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
      r_send_done <= 1'b0;
      r_to_cnt    <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_frame_err <= w_rx_ferr || w_timeout;
      r_to_cnt    <= (w_in_rx && !w_rx_valid) ? r_to_cnt + 1'b1 : '0;
      case (r_state)
        ST_IDLE:
          if (w_rx_valid) begin
            r_is_write <= (w_rx_byte == CMD_WRITE);
            r_cnt      <= '0;
          end
        ST_GET_SIZE:
          if (w_rx_valid) begin
            r_words <= w_rx_byte;
            r_cnt   <= '0;
          end
        ST_GET_ADDR:
          if (w_rx_valid) begin
            r_addr <= {r_addr[23:0], w_rx_byte};
            r_cnt  <= r_cnt + 2'd1;
          end
        ST_GET_DATA:
          if (w_rx_valid) begin
            r_wdata <= {r_wdata[23:0], w_rx_byte};
            r_cnt   <= r_cnt + 2'd1;
          end
        ST_WB_CYCLE:
          if (w_bus_done) begin
            r_cnt       <= '0;
            r_send_done <= 1'b0;
            if (r_is_write) begin
              r_words <= r_words - 8'd1;
              r_addr  <= r_addr + 32'd4;
            end else begin
              r_rdata <= wb_err_i ? ERR_READ_DATA : wb_dat_i;
            end
          end
        ST_SEND: begin
          if (w_tx_start) begin
            r_cnt <= r_cnt + 2'd1;
            if (r_cnt == 2'd3) r_send_done <= 1'b1;
          end
          if (r_send_done && w_tx_ready) begin
            r_words     <= r_words - 8'd1;
            r_addr      <= r_addr + 32'd4;
            r_send_done <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign wb_cyc_o    = (r_state == ST_WB_CYCLE);
  assign wb_stb_o    = wb_cyc_o;
  assign wb_we_o     = wb_cyc_o && r_is_write;
  assign wb_sel_o    = {4{wb_cyc_o}};
  assign wb_adr_o    = r_addr;
  assign wb_dat_o    = r_wdata;
  assign busy_o      = (r_state != ST_IDLE);
  assign frame_err_o = r_frame_err;

endmodule
`default_nettype wire
